// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-requester memory arbiter.
// Default widths and the requester index assignments live here.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 30;
    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic REQ_LSU    = 1'b0;
    localparam logic REQ_IFETCH = 1'b1;

    // Index of the granted requester for a one-hot (or all-zero) grant vector.
    function automatic logic gnt_to_id(input logic [1:0] gnt);
        return gnt[REQ_IFETCH];
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Pure 2-way grant selection: request vector plus last winner -> one-hot grant.
// MEM_ARB_ROUNDROBIN_EN selects alternating grants on contention; otherwise r0 wins.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_id,
    output logic [1:0] gnt
);

`ifndef MEM_ARB_ROUNDROBIN_EN
    logic unused_last_id;
    assign unused_last_id = last_id;
`endif

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
`ifdef MEM_ARB_ROUNDROBIN_EN
            // Contention goes to whoever did not win last time.
            gnt = (last_id == REQ_IFETCH) ? 2'b01 : 2'b10;
`else
            gnt = 2'b01;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter with one-cycle response routing.
// Define MEM_ARB_ROUNDROBIN_EN for round-robin contention; default is fixed priority (r0).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r0_wr,
    output logic              r0_gnt,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,

    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r1_wr,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid,

    output logic              m_active,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wr,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_valid
);

    logic [1:0] req_vec;
    logic [1:0] gnt_vec;
    logic       gnt_id;
    logic       own_vld;
    logic       own_id;
    logic       last_id;

    // Requests are masked during reset so no grant or memory strobe escapes.
    assign req_vec = {r1_req, r0_req} & {2{rst_n}};

    mem_arb_pick u_pick (
        .req     (req_vec),
        .last_id (last_id),
        .gnt     (gnt_vec)
    );

    assign r0_gnt   = gnt_vec[REQ_LSU];
    assign r1_gnt   = gnt_vec[REQ_IFETCH];
    assign gnt_id   = gnt_to_id(gnt_vec);
    assign m_active = r0_gnt | r1_gnt;

    always_comb begin
        m_addr  = r0_addr;
        m_wdata = r0_wdata;
        m_wr    = 1'b0;
        if (r1_gnt) begin
            m_addr  = r1_addr;
            m_wdata = r1_wdata;
            m_wr    = r1_wr;
        end else if (r0_gnt) begin
            m_wr    = r0_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_vld <= 1'b0;
            own_id  <= REQ_LSU;
            last_id <= REQ_IFETCH;
        end else begin
            own_vld <= m_active;
            own_id  <= gnt_id;
            if (m_active) begin
                last_id <= gnt_id;
            end
        end
    end

    assign r0_rvalid = m_valid & own_vld & (own_id == REQ_LSU);
    assign r1_rvalid = m_valid & own_vld & (own_id == REQ_IFETCH);
    assign r0_rdata  = m_rdata;
    assign r1_rdata  = m_rdata;

endmodule
